lsu_mem_port: RTL

// - Load/store port between the multicycle control FSM/datapath and a word-wide memory bus with req/gnt/rvalid handshake.
// - Lane-aligns store data and byte enables; extracts and sign/zero-extends load data.
// - Raises done when an access finishes; the control FSM holds its memory state until then.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_mem_port_if.sv | 30 +++
 rtl/lsu_load_extend.sv | 31 +++
 rtl/lsu_mem_port.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared state encoding, funct3/store-mask constants and byte-lane
//            helpers for the LSU memory port.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] BE_SB = 4'b0001;
    localparam logic [3:0] BE_SH = 4'b0011;
    localparam logic [3:0] BE_SW = 4'b1111;

    function automatic logic [3:0] lane_be(input logic [3:0] mask, input logic [1:0] off);
        return mask << off;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] rdata, input logic [1:0] off);
        return rdata >> {off, 3'b000};
    endfunction

    function automatic logic is_misaligned(input logic       we,
                                           input logic [3:0] mask,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
        if (we)
            return ((mask == BE_SH) && off[0]) || ((mask == BE_SW) && (off != 2'b00));
        else
            return (((funct3 == F3_LH) || (funct3 == F3_LHU)) && off[0]) ||
                   ((funct3 == F3_LW) && (off != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_port_if
// Purpose  : Word-wide memory bus with req/gnt request phase and rvalid
//            read-data phase.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_extend
// Purpose  : Combinational lane extraction and sign/zero extension of a read
//            word according to the load funct3.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);
    logic [31:0] lane;

    always_comb begin
        load_data = '0;
        lane      = lane_extract(rdata, off);
        case (funct3)
            F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            F3_LW:   load_data = lane;
            F3_LBU:  load_data = {24'd0, lane[7:0]};
            F3_LHU:  load_data = {16'd0, lane[15:0]};
            default: load_data = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_port
// Purpose  : Load/store port between the control FSM and a req/gnt/rvalid
//            memory bus. Optional macro: LSU_MISALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [3:0]        req_be_mask,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              busy,
    output logic [31:0]       load_data,
    output logic              bus_err,
    output logic              misalign_err,
    lsu_mem_port_if.master    mem
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e  state, state_nxt;
    logic [1:0]  off;
    logic [2:0]  funct3;
    logic        we;
    logic [CNT_W-1:0] cnt;
    logic        accept, timeout, capture, timeout_hit, mis;
    logic [31:0] ext_data;

`ifdef LSU_MISALIGN_CHK_EN
    assign mis = is_misaligned(req_we, req_be_mask, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            misalign_err <= 1'b0;
        else if (accept)
            misalign_err <= mis;
    end
`else
    assign mis          = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // cnt holds the number of cycles already spent in REQ+WAIT
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        timeout   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = mis ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // a store completing on its last allowed cycle beats the timeout
                if (mem.mem_gnt && we) begin
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    timeout   = 1'b1;
                end else if (mem.mem_gnt) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    timeout   = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    lsu_load_extend u_load_extend (
        .rdata     (mem.mem_rdata),
        .off       (off),
        .funct3    (funct3),
        .load_data (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            off           <= 2'b00;
            funct3        <= 3'b000;
            we            <= 1'b0;
            cnt           <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            load_data     <= '0;
            bus_err       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            state       <= state_nxt;
            done        <= (state_nxt == ST_DONE);
            busy        <= (state_nxt != ST_IDLE);
            mem.mem_req <= (state_nxt == ST_REQ);
            mem.mem_we  <= (state_nxt == ST_REQ) && (accept ? req_we : we);
            cnt         <= ((state == ST_REQ) || (state == ST_WAIT)) ? cnt + CNT_W'(1) : '0;
            if (accept) begin
                off           <= req_addr[1:0];
                funct3        <= req_funct3;
                we            <= req_we;
                mem.mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem.mem_be    <= lane_be(req_be_mask, req_addr[1:0]);
                mem.mem_wdata <= lane_wdata(req_wdata, req_addr[1:0]);
                bus_err       <= 1'b0;
            end
            if (timeout)
                bus_err <= 1'b1;
            if (capture)
                load_data <= ext_data;
        end
    end
endmodule
`default_nettype wire
